// File: rtl/brp_gshare.sv
// brp_gshare: gshare conditional-branch predictor.
// Table of saturating counters indexed by PC XOR global history,
// initialised by a post-reset sweep, with prediction-accuracy statistics.
module brp_gshare #(
    parameter int IDX_BITS = 8,
    parameter int GHR_BITS = 8,
    parameter int CTR_BITS = 2,
    parameter int PC_LSB   = 2
) (
    input  logic                clk,
    input  logic                rst,
    output logic                ready_o,
    input  logic                lk_valid_i,
    input  logic [31:0]         lk_pc_i,
    output logic                lk_taken_o,
    output logic [IDX_BITS-1:0] lk_idx_o,
    input  logic                up_valid_i,
    input  logic [IDX_BITS-1:0] up_idx_i,
    input  logic                up_taken_i,
    input  logic                up_pred_i,
    output logic [GHR_BITS-1:0] ghr_o,
    output logic [31:0]         stat_total_o,
    output logic [31:0]         stat_correct_o
);

    localparam int N = 1 << IDX_BITS;
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0] CTR_WNT  = {1'b0, {(CTR_BITS-1){1'b1}}};
    localparam logic [IDX_BITS-1:0] PTR_LAST = '1;

    typedef enum logic {INIT, READY} state_t;

    state_t              state, state_next;
    logic [IDX_BITS-1:0] ptr;
    logic [CTR_BITS-1:0] ctr_tab [N];
    logic [GHR_BITS-1:0] ghr;
    logic [31:0]         stat_total, stat_correct;
    logic [CTR_BITS-1:0] ctr_cur, ctr_next;
    logic                upd;
    logic                unused_pc;

    // PC bits outside the index field do not take part in prediction
    assign unused_pc = ^lk_pc_i;

    assign upd = (state == READY) && up_valid_i;

    // Next-state logic: sweep finishes after the last entry is written
    always_comb begin
        state_next = state;
        if (state == INIT && ptr == PTR_LAST)
            state_next = READY;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= INIT;
        else     state <= state_next;
    end

    // Sweep pointer walks every entry once per INIT pass
    always_ff @(posedge clk) begin
        if (rst)                ptr <= '0;
        else if (state == INIT) ptr <= ptr + IDX_BITS'(1);
    end

    // Saturating counter step for the resolved branch
    always_comb begin
        ctr_cur  = ctr_tab[up_idx_i];
        ctr_next = ctr_cur;
        if (up_taken_i) begin
            if (ctr_cur != CTR_MAX) ctr_next = ctr_cur + CTR_BITS'(1);
        end else begin
            if (ctr_cur != '0)      ctr_next = ctr_cur - CTR_BITS'(1);
        end
    end

    // Counter table: sweep writes weakly-not-taken, READY applies updates.
    // Contents are not reset directly; the sweep rewrites every entry.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == INIT) ctr_tab[ptr]      <= CTR_WNT;
            else if (upd)      ctr_tab[up_idx_i] <= ctr_next;
        end
    end

    // Non-speculative history and accuracy counters, updated at resolution
    always_ff @(posedge clk) begin
        if (rst) begin
            ghr          <= '0;
            stat_total   <= '0;
            stat_correct <= '0;
        end else if (upd) begin
            ghr        <= (ghr << 1) | GHR_BITS'(up_taken_i);
            stat_total <= stat_total + 32'd1;
            if (up_pred_i == up_taken_i)
                stat_correct <= stat_correct + 32'd1;
        end
    end

    // Lookup reads the pre-update table and history (read-before-write)
    assign lk_idx_o   = lk_pc_i[PC_LSB +: IDX_BITS] ^ IDX_BITS'(ghr);
    assign lk_taken_o = (state == READY) && lk_valid_i && ctr_tab[lk_idx_o][CTR_BITS-1];

    assign ready_o        = (state == READY);
    assign ghr_o          = ghr;
    assign stat_total_o   = stat_total;
    assign stat_correct_o = stat_correct;

endmodule

// File: tb/tb_brp_gshare.sv
// tb_brp_gshare: directed self-checking bench for brp_gshare
// (IDX_BITS=4, GHR_BITS=4, CTR_BITS=2, PC_LSB=2).
module tb_brp_gshare;

    localparam int IDX_BITS = 4;
    localparam int GHR_BITS = 4;
    localparam int CTR_BITS = 2;
    localparam int PC_LSB   = 2;
    localparam int N        = 16;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                ready_o;
    logic                lk_valid_i = 1'b0;
    logic [31:0]         lk_pc_i = '0;
    logic                lk_taken_o;
    logic [IDX_BITS-1:0] lk_idx_o;
    logic                up_valid_i = 1'b0;
    logic [IDX_BITS-1:0] up_idx_i = '0;
    logic                up_taken_i = 1'b0;
    logic                up_pred_i = 1'b0;
    logic [GHR_BITS-1:0] ghr_o;
    logic [31:0]         stat_total_o;
    logic [31:0]         stat_correct_o;

    int errors = 0;
    int checks = 0;
    logic [GHR_BITS-1:0] ghr_m = '0;

    brp_gshare #(
        .IDX_BITS(IDX_BITS), .GHR_BITS(GHR_BITS),
        .CTR_BITS(CTR_BITS), .PC_LSB(PC_LSB)
    ) dut (
        .clk(clk), .rst(rst), .ready_o(ready_o),
        .lk_valid_i(lk_valid_i), .lk_pc_i(lk_pc_i),
        .lk_taken_o(lk_taken_o), .lk_idx_o(lk_idx_o),
        .up_valid_i(up_valid_i), .up_idx_i(up_idx_i),
        .up_taken_i(up_taken_i), .up_pred_i(up_pred_i),
        .ghr_o(ghr_o), .stat_total_o(stat_total_o), .stat_correct_o(stat_correct_o)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Point the lookup at a given table index under the current history
    task automatic look(input int idx);
        logic [IDX_BITS-1:0] f;
        f = IDX_BITS'(idx) ^ IDX_BITS'(ghr_m);
        lk_valid_i = 1'b1;
        lk_pc_i    = 32'(f) << PC_LSB;
        #1;
    endtask

    // One resolved branch, then idle
    task automatic do_update(input int idx, input logic taken, input logic pred);
        up_valid_i = 1'b1;
        up_idx_i   = IDX_BITS'(idx);
        up_taken_i = taken;
        up_pred_i  = pred;
        tick();
        up_valid_i = 1'b0;
        ghr_m = {ghr_m[GHR_BITS-2:0], taken};
    endtask

    // Reset and run the sweep to completion
    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ghr_m = '0;
        repeat (N) tick();
    endtask

    task automatic test_reset();
        int bad;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        ghr_m = '0;
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", ready_o); end
        checks++; if (ghr_o !== 4'h0) begin errors++; $display("FAIL reset_ghr got=%h exp=0", ghr_o); end
        checks++; if (stat_total_o !== 32'd0 || stat_correct_o !== 32'd0) begin
            errors++; $display("FAIL reset_stats got=%0d/%0d exp=0/0", stat_total_o, stat_correct_o); end
        // 15 edges of sweep: ready stays low, lookups and updates are ignored
        bad = 0;
        lk_valid_i = 1'b1;
        for (int i = 1; i < N; i++) begin
            up_valid_i = 1'b1; up_idx_i = 4'd1; up_taken_i = 1'b1; up_pred_i = 1'b1;
            lk_pc_i = 32'(i) << PC_LSB;
            tick();
            if (ready_o !== 1'b0 || lk_taken_o !== 1'b0) bad++;
        end
        up_valid_i = 1'b0;
        checks++; if (bad !== 0) begin errors++; $display("FAIL init_ready_low bad_cycles=%0d exp=0", bad); end
        checks++; if (stat_total_o !== 32'd0 || stat_correct_o !== 32'd0 || ghr_o !== 4'h0) begin
            errors++; $display("FAIL init_ignores_update got=%0d/%0d ghr=%h exp=0/0 ghr=0", stat_total_o, stat_correct_o, ghr_o); end
        tick();
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL ready_after_N got=%b exp=1", ready_o); end
        // every entry weakly not-taken
        bad = 0;
        for (int i = 0; i < N; i++) begin
            look(i);
            if (lk_taken_o !== 1'b0 || lk_idx_o !== IDX_BITS'(i)) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL init_all_weak_nt bad_entries=%0d exp=0", bad); end
        lk_valid_i = 1'b0;
    endtask

    task automatic test_saturation();
        logic exp_t [6];
        exp_t = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            do_update(5, (i < 3), 1'b0);
            look(5);
            checks++; if (lk_idx_o !== 4'd5) begin errors++; $display("FAIL sat_idx[%0d] got=%0d exp=5", i, lk_idx_o); end
            checks++; if (lk_taken_o !== exp_t[i]) begin errors++; $display("FAIL sat_pred[%0d] got=%b exp=%b", i, lk_taken_o, exp_t[i]); end
        end
        // counter now 00: one taken step gives 01, still not-taken (proves floor held)
        do_update(5, 1'b1, 1'b0);
        look(5);
        checks++; if (lk_taken_o !== 1'b0) begin errors++; $display("FAIL sat_floor got=%b exp=0", lk_taken_o); end
        lk_valid_i = 1'b0;
    endtask

    task automatic test_history();
        do_reset();
        do_update(0, 1'b1, 1'b0);
        do_update(0, 1'b0, 1'b0);
        do_update(0, 1'b1, 1'b0);
        checks++; if (ghr_o !== 4'b0101) begin errors++; $display("FAIL ghr got=%b exp=0101", ghr_o); end
        lk_valid_i = 1'b1;
        lk_pc_i    = 32'h0000_0020;
        #1;
        checks++; if (lk_idx_o !== 4'd13) begin errors++; $display("FAIL hist_idx got=%0d exp=13", lk_idx_o); end
        lk_valid_i = 1'b0;
    endtask

    task automatic test_rbw();
        // idx 9 still at 01; lookup and taken update in the same cycle
        look(9);
        up_valid_i = 1'b1; up_idx_i = 4'd9; up_taken_i = 1'b1; up_pred_i = 1'b0;
        #1;
        checks++; if (lk_taken_o !== 1'b0) begin errors++; $display("FAIL rbw_same_cycle got=%b exp=0", lk_taken_o); end
        tick();
        up_valid_i = 1'b0;
        ghr_m = {ghr_m[GHR_BITS-2:0], 1'b1};
        look(9);
        checks++; if (lk_taken_o !== 1'b1) begin errors++; $display("FAIL rbw_next_cycle got=%b exp=1", lk_taken_o); end
        lk_valid_i = 1'b0;
    endtask

    task automatic test_stats();
        logic [9:0] tk, mm;
        do_reset();
        tk = 10'b1011001110;
        mm = 10'b0010010001;   // three mispredictions
        for (int i = 0; i < 10; i++)
            do_update(2, tk[i], tk[i] ^ mm[i]);
        checks++; if (stat_total_o !== 32'd10) begin errors++; $display("FAIL stat_total got=%0d exp=10", stat_total_o); end
        checks++; if (stat_correct_o !== 32'd7) begin errors++; $display("FAIL stat_correct got=%0d exp=7", stat_correct_o); end
        // updates offered during INIT leave stats untouched
        rst = 1'b1; tick(); rst = 1'b0; ghr_m = '0;
        for (int i = 0; i < 4; i++) do_update(2, 1'b1, 1'b1);
        ghr_m = '0;
        checks++; if (stat_total_o !== 32'd0 || stat_correct_o !== 32'd0) begin
            errors++; $display("FAIL stat_init_ignored got=%0d/%0d exp=0/0", stat_total_o, stat_correct_o); end
        repeat (N - 4) tick();
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL stat_ready got=%b exp=1", ready_o); end
    endtask

    task automatic test_reset_mid();
        int bad;
        do_update(3, 1'b1, 1'b0);
        do_update(3, 1'b1, 1'b1);
        look(3);
        checks++; if (lk_taken_o !== 1'b1) begin errors++; $display("FAIL mid_trained got=%b exp=1", lk_taken_o); end
        lk_valid_i = 1'b0;
        #1;
        checks++; if (lk_taken_o !== 1'b0) begin errors++; $display("FAIL lk_valid_gate got=%b exp=0", lk_taken_o); end
        // reset with a same-cycle update: reset wins
        rst = 1'b1;
        up_valid_i = 1'b1; up_idx_i = 4'd3; up_taken_i = 1'b1; up_pred_i = 1'b1;
        tick();
        rst = 1'b0; up_valid_i = 1'b0; ghr_m = '0;
        checks++; if (ghr_o !== 4'h0 || stat_total_o !== 32'd0 || stat_correct_o !== 32'd0 || ready_o !== 1'b0) begin
            errors++; $display("FAIL mid_reset_state got ghr=%h tot=%0d cor=%0d rdy=%b exp 0/0/0/0",
                               ghr_o, stat_total_o, stat_correct_o, ready_o); end
        // reset again in the middle of the sweep: sweep restarts from 0
        repeat (5) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        bad = 0;
        for (int i = 1; i < N; i++) begin
            tick();
            if (ready_o !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL mid_init_restart bad_cycles=%0d exp=0", bad); end
        tick();
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL mid_ready got=%b exp=1", ready_o); end
        look(3);
        checks++; if (lk_taken_o !== 1'b0) begin errors++; $display("FAIL mid_idx3_cleared got=%b exp=0", lk_taken_o); end
        lk_valid_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_saturation();
        test_history();
        test_rbw();
        test_stats();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
